// File: rtl/immunit_pipe_if.sv
// immunit_pipe_if: handshake and data bundle between decode and execute
// around the immediate generator.
//   InValid/InReady/ImmInput/ImmSrc/InTag : input beat (decode -> block)
//   OutValid/OutReady/ImmExt/OutTag/Err   : head result (block -> execute)
// modport slave  : the immediate generator itself
// modport master : the environment (decode producer + execute consumer)
interface immunit_pipe_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
);
  logic             InValid;
  logic             InReady;
  logic [24:0]      ImmInput;
  logic [2:0]       ImmSrc;
  logic [TAG_W-1:0] InTag;
  logic             OutValid;
  logic             OutReady;
  logic [XLEN-1:0]  ImmExt;
  logic [TAG_W-1:0] OutTag;
  logic             Err;

  modport slave (
    input  InValid, ImmInput, ImmSrc, InTag, OutReady,
    output InReady, OutValid, ImmExt, OutTag, Err
  );

  modport master (
    output InValid, ImmInput, ImmSrc, InTag, OutReady,
    input  InReady, OutValid, ImmExt, OutTag, Err
  );
endinterface

// File: rtl/immunit_pipe.sv
// immunit_pipe: registered immediate generator. Decodes instruction bits
// [31:7] into an XLEN-wide immediate and queues {imm, tag, err} in a
// DEPTH-entry FIFO with valid/ready on both sides.
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset (same effect as Flush)
//   Flush : synchronous clear of all queued results
//   Count : current FIFO occupancy
//   bus   : immunit_pipe_if.slave (input beat + head result handshakes)
module immunit_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAG_W = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       Flush,
  output logic [$clog2(DEPTH):0]     Count,
  immunit_pipe_if.slave              bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = XLEN + TAG_W + 1;

  typedef enum logic [2:0] {
    SRC_I     = 3'b000,
    SRC_S     = 3'b001,
    SRC_U     = 3'b010,
    SRC_Z     = 3'b011,
    SRC_SHAMT = 3'b100,
    SRC_B     = 3'b101,
    SRC_J     = 3'b110,
    SRC_ILL   = 3'b111
  } immSrc_e;

  logic [XLEN-1:0] decImm;
  logic            decErr;
  logic [24:0]     ii;

  assign ii = bus.ImmInput;

  // Sign extension is done by filling the whole word with the sign bit and
  // then overwriting the low field, which works for any XLEN >= 32.
  always_comb begin
    decImm = '0;
    decErr = 1'b0;
    case (immSrc_e'(bus.ImmSrc))
      SRC_I: begin
        decImm        = {XLEN{ii[24]}};
        decImm[11:0]  = ii[24:13];
      end
      SRC_S: begin
        decImm        = {XLEN{ii[24]}};
        decImm[11:0]  = {ii[24:18], ii[4:0]};
      end
      SRC_U: begin
        decImm        = {XLEN{ii[24]}};
        decImm[31:0]  = {ii[24:5], 12'b0};
      end
      SRC_Z: begin
        decImm[4:0]   = ii[12:8];
      end
      SRC_SHAMT: begin
        if (XLEN == 64) decImm[5:0] = ii[18:13];
        else            decImm[4:0] = ii[17:13];
      end
      SRC_B: begin
        decImm        = {XLEN{ii[24]}};
        decImm[12:0]  = {ii[24], ii[0], ii[23:18], ii[4:1], 1'b0};
      end
      SRC_J: begin
        decImm        = {XLEN{ii[24]}};
        decImm[20:0]  = {ii[24], ii[12:5], ii[13], ii[23:14], 1'b0};
      end
      default: begin
        decImm = '0;
        decErr = 1'b1;
      end
    endcase
  end

  logic [EW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;
  logic [XLEN-1:0]  headImm;
  logic [TAG_W-1:0] headTag;
  logic             headErr;

  assign bus.InReady  = (count < CW'(DEPTH));
  assign bus.OutValid = (count != '0);
  assign push         = bus.InValid && bus.InReady;
  assign pop          = bus.OutValid && bus.OutReady;

  // Storage is not reset; the head outputs are masked while empty instead.
  always_ff @(posedge clk) begin
    if (push && !Flush && !rst) begin
      mem[wrPtr] <= {decImm, bus.InTag, decErr};
    end
  end

  always_ff @(posedge clk) begin
    if (rst || Flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign {headImm, headTag, headErr} = mem[rdPtr];

  assign bus.ImmExt = bus.OutValid ? headImm : '0;
  assign bus.OutTag = bus.OutValid ? headTag : '0;
  assign bus.Err    = bus.OutValid ? headErr : 1'b0;
  assign Count      = count;
endmodule

// File: doc/immunit_pipe.md
Name: immunit_pipe

Overview:
Registered, parametrised immediate generator for the pipelined core. It takes instruction bits [31:7] and an immediate-type select, and produces an XLEN-wide extended immediate. Decoded results pass through a DEPTH-entry FIFO with valid/ready handshakes on both sides and a passthrough tag. It sits between the decode and execute stages and adds CSR-uimm and shift-amount formats, an illegal-select error flag and a flush.

Parameters:
XLEN, 32, output width; legal values are 32 or 64.
DEPTH, 2, result FIFO entries; a power of two, at least 2.
TAG_W, 5, width of the sideband tag carried with each result (e.g. rd).

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  reset; synchronous, active-high.
Flush  in  1  synchronous clear of all FIFO contents.
InValid  in  1  input beat valid.
InReady  out  1  block can accept a beat.
ImmInput  in  25  instruction bits [31:7]; ImmInput[k] = instr[k+7].
ImmSrc  in  3  immediate format select.
InTag  in  TAG_W  sideband tag, stored with the result.
OutValid  out  1  head result valid.
OutReady  in  1  consumer accepts the head result.
ImmExt  out  XLEN  head immediate.
OutTag  out  TAG_W  head tag.
Err  out  1  head was produced from an illegal ImmSrc.
Count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Decode (combinational, on the input side; s() = sign-extend to XLEN, z() = zero-extend):
  - 000 I: s(ImmInput[24:13])
  - 001 S: s({ImmInput[24:18], ImmInput[4:0]})
  - 010 U: s({ImmInput[24:5], 12'b0}); XLEN=64 sign-extends from bit 31.
  - 011 Z (CSR uimm): z(ImmInput[12:8])
  - 100 SHAMT: z(ImmInput[17:13]) when XLEN=32, z(ImmInput[18:13]) when XLEN=64.
  - 101 B: s({ImmInput[24], ImmInput[0], ImmInput[23:18], ImmInput[4:1], 1'b0})
  - 110 J: s({ImmInput[24], ImmInput[12:5], ImmInput[13], ImmInput[23:14], 1'b0})
  - 111: illegal; ImmExt = 0 and Err = 1. For every other code Err = 0.
- Push: occurs on InValid && InReady. Stores {ImmExt, InTag, Err} at the write pointer.
- Pop: occurs on OutValid && OutReady. Advances the read pointer.
- InReady = (Count < DEPTH). It is combinational from the registered count only, never from OutReady; there is no same-cycle pass-through when full.
- OutValid = (Count != 0). ImmExt, OutTag and Err show the head entry and are stable while OutValid && !OutReady.
- Latency: a beat accepted in cycle N is visible at the head in cycle N+1 at the earliest. With no backpressure, throughput is one beat per cycle.
- Simultaneous push and pop with 0 < Count < DEPTH: Count is unchanged and both pointers advance.
- Push and pop on an empty FIFO: only the push takes effect (nothing to pop); Count becomes 1.
- Pointers wrap modulo DEPTH.
- Flush: Count becomes 0 and pointers return to 0 on the next edge. Flush overrides a push and a pop in the same cycle; the pushed beat is dropped.
- rst has the same effect as Flush. Reset values: Count=0, OutValid=0, InReady=1, and ImmExt=0, OutTag=0, Err=0 while empty. Asserting rst mid-stream discards all entries.
- ImmInput, ImmSrc and InTag are don't-care while InValid=0.

Test Plan:
1. Per-format decode, XLEN=32, OutReady=1. Each row is ImmSrc, ImmInput -> ImmExt, with Err=0 unless stated:
   - I: 000, 0x1FF6000 -> 0xFFFFFFFB
   - S: 001, 0x0800002 -> 0x00000402
   - B: 101, 0x1FC0019 -> 0xFFFFFFF8
   - U: 010, 0x02468A0 -> 0x12345000
   - J: 110, 0x0002000 -> 0x00000800
   - Z: 011, 0x0001F00 -> 0x0000001F
   - Illegal: 111, any value -> 0x00000000, Err=1
2. XLEN=64: U with ImmInput=0x1000000 -> 0xFFFFFFFF80000000. SHAMT with ImmInput[18:13]=6'h3F -> 0x3F.
3. Backpressure, DEPTH=2: OutReady=0, push tags 1, 2, 3. Tag 3 is held off: InReady=0 once Count=2. Then OutReady=1; OutTag reads 1 then 2, and tag 3 is accepted as soon as InReady returns.
4. Streaming: InValid=1 and OutReady=1 for 8 cycles with tags 0..7. Outputs appear in order, one per cycle, one cycle late; Count stays 1.
5. Flush with Count=2, InValid=1 and OutReady=1 in the same cycle: next cycle Count=0 and OutValid=0; the flushed beat's tag never appears.
6. rst asserted mid-stream with Count=1: next cycle all outputs are at their reset values. Reset values are also checked after power-up.
